pic_inta_seq: RTL and testbench

PIC_INTA_SEQ -- requirements
Module: pic_inta_seq

---
 rtl/pic_pkg.sv | 21 ++
 rtl/pic_inta_seq_if.sv | 29 ++
 rtl/pic_prio_enc.sv | 22 ++
 rtl/pic_inta_seq.sv | 124 ++++++++++++
 tb/tb_pic_inta_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types for the interrupt-acknowledge sequencer: IRQ count, level type and FSM states.
package pic_pkg;

    localparam int NUM_IRQ = 8;

    typedef logic [2:0] level_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        GAP,
        ACK2
    } state_t;

    function automatic logic [NUM_IRQ-1:0] level_onehot(input level_t lvl);
        level_onehot      = '0;
        level_onehot[lvl] = 1'b1;
    endfunction

endpackage

// File: rtl/pic_inta_seq_if.sv
// Resolver/CPU-side bundle of the acknowledge sequencer; master drives requests and strobes.
interface pic_inta_seq_if;
    import pic_pkg::*;

    logic               req_valid;
    level_t             req_level;
    logic               inta_n;
    logic               eoi;
    logic               eoi_specific;
    level_t             eoi_level;
    logic               aeoi;
    logic [4:0]         vector_base;
    logic               int_out;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] irr_clear;
    logic [7:0]         data_out;
    logic               data_oe;

    modport master (
        output req_valid, req_level, inta_n, eoi, eoi_specific, eoi_level, aeoi, vector_base,
        input  int_out, isr, irr_clear, data_out, data_oe
    );

    modport slave (
        input  req_valid, req_level, inta_n, eoi, eoi_specific, eoi_level, aeoi, vector_base,
        output int_out, isr, irr_clear, data_out, data_oe
    );

endinterface

// File: rtl/pic_prio_enc.sv
// Lowest-set-bit encoder: index 0 is the highest priority; valid is low when no bit is set.
module pic_prio_enc
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] bits,
    output level_t             idx,
    output logic               valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx   = level_t'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_inta_seq.sv
// 8259-style INTA sequencer: raises INT, runs the two-pulse acknowledge, drives the vector
// and maintains the in-service register with EOI/AEOI handling.
module pic_inta_seq
    import pic_pkg::*;
#(
    parameter level_t SPURIOUS_LEVEL = 3'd7
) (
    input  logic            clk,
    input  logic            reset,
    pic_inta_seq_if.slave   bus
);

    state_t             state;
    logic               inta_prev;
    level_t             lvl;
    logic               spurious;
    logic               int_out_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [NUM_IRQ-1:0] irr_clear_q;
    logic [7:0]         data_out_q;
    logic               data_oe_q;

    level_t             isr_low;
    logic               isr_any;
    logic               inta_fall;
    logic               inta_rise;
    logic               qualify;
    logic [NUM_IRQ-1:0] isr_clr;
    logic [NUM_IRQ-1:0] isr_set;

    pic_prio_enc u_isr_enc (
        .bits  (isr_q),
        .idx   (isr_low),
        .valid (isr_any)
    );

    assign inta_fall = inta_prev & ~bus.inta_n;
    assign inta_rise = ~inta_prev & bus.inta_n;
    assign qualify   = bus.req_valid && (!isr_any || (bus.req_level < isr_low));

    // Clears and set are separate masks so a set on the same edge always wins.
    always_comb begin
        isr_clr = '0;
        isr_set = '0;
        if (bus.eoi) begin
            if (bus.eoi_specific)
                isr_clr = level_onehot(bus.eoi_level);
            else if (isr_any)
                isr_clr = level_onehot(isr_low);
        end
        if (state == ACK2 && inta_rise && bus.aeoi && !spurious)
            isr_clr = isr_clr | level_onehot(lvl);
        if (state == REQ && inta_fall && bus.req_valid)
            isr_set = level_onehot(bus.req_level);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            inta_prev   <= 1'b1;
            lvl         <= '0;
            spurious    <= 1'b0;
            int_out_q   <= 1'b0;
            isr_q       <= '0;
            irr_clear_q <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            inta_prev   <= bus.inta_n;
            isr_q       <= (isr_q & ~isr_clr) | isr_set;
            irr_clear_q <= isr_set;
            case (state)
                IDLE: begin
                    if (inta_fall) begin
                        state    <= ACK1;
                        lvl      <= SPURIOUS_LEVEL;
                        spurious <= 1'b1;
                    end else if (qualify) begin
                        state     <= REQ;
                        int_out_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (inta_fall) begin
                        state     <= ACK1;
                        int_out_q <= 1'b0;
                        spurious  <= !bus.req_valid;
                        lvl       <= bus.req_valid ? bus.req_level : SPURIOUS_LEVEL;
                    end else if (!qualify) begin
                        state     <= IDLE;
                        int_out_q <= 1'b0;
                    end
                end
                ACK1: begin
                    if (inta_rise)
                        state <= GAP;
                end
                GAP: begin
                    if (inta_fall) begin
                        state      <= ACK2;
                        data_out_q <= {bus.vector_base, lvl};
                        data_oe_q  <= 1'b1;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        state      <= IDLE;
                        data_out_q <= '0;
                        data_oe_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.int_out   = int_out_q;
    assign bus.isr       = isr_q;
    assign bus.irr_clear = irr_clear_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;

endmodule

// File: tb/tb_pic_inta_seq.sv
// Directed bench for pic_inta_seq: nested requests, spurious acks, AEOI, EOI and reset abort.
module tb_pic_inta_seq;
    import pic_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pic_inta_seq_if bus ();

    pic_inta_seq #(.SPURIOUS_LEVEL(3'd7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled right after the falling edge.
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic eoi_cmd(input logic specific, input level_t level);
        bus.eoi          = 1'b1;
        bus.eoi_specific = specific;
        bus.eoi_level    = level;
        step();
        bus.eoi = 1'b0;
    endtask

    // Full two-pulse acknowledge starting from REQ with int_out already high.
    task automatic ack(input string tag, input logic [7:0] isr1, input logic [7:0] irr,
                       input logic [7:0] vec, input logic [7:0] isr_end);
        bus.inta_n = 1'b0;
        step();
        check({tag, ".isr1"}, bus.isr, isr1);
        check({tag, ".irr"}, bus.irr_clear, irr);
        check({tag, ".int_off"}, bus.int_out, 1'b0);
        bus.req_valid = 1'b0;
        step();
        check({tag, ".irr_pulse"}, bus.irr_clear, 8'h00);
        bus.inta_n = 1'b1;
        step();
        check({tag, ".gap_oe"}, bus.data_oe, 1'b0);
        bus.inta_n = 1'b0;
        step();
        check({tag, ".vec"}, bus.data_out, vec);
        check({tag, ".oe"}, bus.data_oe, 1'b1);
        check({tag, ".isr_ack2"}, bus.isr, isr1);
        bus.inta_n = 1'b1;
        step();
        check({tag, ".oe_off"}, bus.data_oe, 1'b0);
        check({tag, ".data_off"}, bus.data_out, 8'h00);
        check({tag, ".isr_end"}, bus.isr, isr_end);
    endtask

    task automatic raise(input string tag, input level_t level);
        bus.req_valid = 1'b1;
        bus.req_level = level;
        step();
        check({tag, ".int"}, bus.int_out, 1'b1);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_level    = '0;
        bus.inta_n       = 1'b1;
        bus.eoi          = 1'b0;
        bus.eoi_specific = 1'b0;
        bus.eoi_level    = '0;
        bus.aeoi         = 1'b0;
        bus.vector_base  = 5'h08;
        step(3);
        check("rst.int", bus.int_out, 1'b0);
        check("rst.isr", bus.isr, 8'h00);
        check("rst.irr", bus.irr_clear, 8'h00);
        check("rst.data", bus.data_out, 8'h00);
        check("rst.oe", bus.data_oe, 1'b0);
        reset = 1'b0;
        step();

        // Basic level-3 acknowledge, vector {08,3} = 0x43.
        bus.req_valid = 1'b1;
        bus.req_level = 3'd3;
        check("l3.int_pre", bus.int_out, 1'b0);
        step();
        check("l3.int", bus.int_out, 1'b1);
        ack("l3", 8'h08, 8'h08, 8'h43, 8'h08);

        // Nested priority: level 5 blocked by in-service 3, level 1 preempts.
        bus.req_valid = 1'b1;
        bus.req_level = 3'd5;
        step(2);
        check("nest.blocked", bus.int_out, 1'b0);
        raise("nest.l1", 3'd1);
        ack("nest", 8'h0a, 8'h02, 8'h41, 8'h0a);
        eoi_cmd(1'b1, 3'd1);
        check("nest.seoi1", bus.isr, 8'h08);
        eoi_cmd(1'b1, 3'd3);
        check("nest.seoi3", bus.isr, 8'h00);

        // Request withdrawn at the first INTA fall: spurious level 7.
        raise("spur", 3'd4);
        bus.req_valid = 1'b0;
        bus.inta_n    = 1'b0;
        step();
        check("spur.isr", bus.isr, 8'h00);
        check("spur.irr", bus.irr_clear, 8'h00);
        check("spur.int", bus.int_out, 1'b0);
        bus.inta_n = 1'b1;
        step();
        bus.inta_n = 1'b0;
        step();
        check("spur.vec", bus.data_out, 8'h47);
        check("spur.oe", bus.data_oe, 1'b1);
        bus.inta_n = 1'b1;
        step();
        check("spur.oe_off", bus.data_oe, 1'b0);

        // Automatic EOI on level 2.
        bus.aeoi = 1'b1;
        raise("aeoi", 3'd2);
        ack("aeoi", 8'h04, 8'h04, 8'h42, 8'h00);
        bus.aeoi = 1'b0;

        // Non-specific and specific EOI, then EOI on an empty ISR.
        raise("eoi.l5", 3'd5);
        ack("eoi.l5", 8'h20, 8'h20, 8'h45, 8'h20);
        raise("eoi.l2", 3'd2);
        ack("eoi.l2", 8'h24, 8'h04, 8'h42, 8'h24);
        eoi_cmd(1'b0, 3'd0);
        check("eoi.ns", bus.isr, 8'h20);
        eoi_cmd(1'b1, 3'd5);
        check("eoi.sp5", bus.isr, 8'h00);
        eoi_cmd(1'b0, 3'd0);
        check("eoi.empty", bus.isr, 8'h00);

        // Specific EOI and ISR set on the same bit and edge: set wins.
        raise("coin", 3'd3);
        bus.eoi          = 1'b1;
        bus.eoi_specific = 1'b1;
        bus.eoi_level    = 3'd3;
        bus.inta_n       = 1'b0;
        step();
        bus.eoi       = 1'b0;
        bus.req_valid = 1'b0;
        check("coin.isr", bus.isr, 8'h08);
        bus.inta_n = 1'b1;
        step();
        bus.inta_n = 1'b0;
        step();
        check("coin.vec", bus.data_out, 8'h43);
        bus.inta_n = 1'b1;
        step();
        eoi_cmd(1'b1, 3'd3);
        check("coin.clr", bus.isr, 8'h00);

        // Reset during GAP aborts at once; the next INTA drives no vector.
        raise("rgap", 3'd0);
        bus.inta_n = 1'b0;
        step();
        check("rgap.isr", bus.isr, 8'h01);
        bus.req_valid = 1'b0;
        bus.inta_n    = 1'b1;
        step();
        #2 reset = 1'b1;
        #1;
        check("rgap.int", bus.int_out, 1'b0);
        check("rgap.isr_rst", bus.isr, 8'h00);
        check("rgap.irr", bus.irr_clear, 8'h00);
        check("rgap.data", bus.data_out, 8'h00);
        check("rgap.oe", bus.data_oe, 1'b0);
        step();
        reset = 1'b0;
        step();
        bus.inta_n = 1'b0;
        step(2);
        check("rgap.next_oe", bus.data_oe, 1'b0);
        check("rgap.next_isr", bus.isr, 8'h00);
        bus.inta_n = 1'b1;
        step();
        bus.inta_n = 1'b0;
        step();
        check("rgap.spur_vec", bus.data_out, 8'h47);
        bus.inta_n = 1'b1;
        step();
        check("rgap.idle_oe", bus.data_oe, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
